// File: rtl/vlsu_meta_arbiter_if.sv
// vlsu_meta_arbiter_if: meta-request, meta-info, beat-commit and status signals of the meta arbiter.
// slave: arbiter side (takes requests and beats, drives meta info, done and status).
// master: environment side (requesters, deshuffle unit and commit logic).
interface vlsu_meta_arbiter_if #(
    parameter int NrReq      = 2,
    parameter int CmtCntBits = 8,
    parameter int ReqIdBits  = 4
);
    localparam int SrcBits = (NrReq > 1) ? $clog2(NrReq) : 1;
    logic [NrReq-1:0]                 req_valid_i;
    logic [NrReq-1:0]                 req_ready_o;
    logic [NrReq-1:0][ReqIdBits-1:0]  req_reqid_i;
    logic [NrReq-1:0][CmtCntBits-1:0] req_beats_i;
    logic                             meta_valid_o;
    logic                             meta_ready_i;
    logic [ReqIdBits-1:0]             meta_reqid_o;
    logic [CmtCntBits-1:0]            meta_cmtcnt_o;
    logic [SrcBits-1:0]               meta_src_o;
    logic                             beat_done_i;
    logic                             done_valid_o;
    logic [SrcBits-1:0]               done_src_o;
    logic [ReqIdBits-1:0]             done_reqid_o;
    logic                             busy_o;
    logic                             err_o;
    modport slave (
        input  req_valid_i, req_reqid_i, req_beats_i, meta_ready_i, beat_done_i,
        output req_ready_o, meta_valid_o, meta_reqid_o, meta_cmtcnt_o, meta_src_o,
               done_valid_o, done_src_o, done_reqid_o, busy_o, err_o
    );
    modport master (
        output req_valid_i, req_reqid_i, req_beats_i, meta_ready_i, beat_done_i,
        input  req_ready_o, meta_valid_o, meta_reqid_o, meta_cmtcnt_o, meta_src_o,
               done_valid_o, done_src_o, done_reqid_o, busy_o, err_o
    );
endinterface

// File: rtl/vlsu_meta_arbiter.sv
// vlsu_meta_arbiter: round-robin meta-info arbiter with an in-flight tracker that retires requests on committed beats.
// clk_i/rst_i: clock and synchronous active-high reset.
// bus (slave): requester handshakes, registered meta-info output, beat_done input, done pulse, busy and sticky error.
module vlsu_meta_arbiter #(
    parameter int NrReq          = 2,
    parameter int MaxOutstanding = 4,
    parameter int CmtCntBits     = 8,
    parameter int ReqIdBits      = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    vlsu_meta_arbiter_if.slave bus
);
    localparam int SrcBits = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int PtrBits = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    typedef enum logic {EMPTY, FULL} state_e;
    state_e                r_state;
    logic [SrcBits-1:0]    r_rr_ptr, r_meta_src, r_done_src;
    logic [ReqIdBits-1:0]  r_meta_id, r_done_id;
    logic [CmtCntBits-1:0] r_meta_cmt, r_cnt;
    logic                  r_done_valid, r_err, r_wf, r_rf;
    logic [PtrBits-1:0]    r_wr, r_rd;
    logic [SrcBits-1:0]    r_t_src [MaxOutstanding];
    logic [ReqIdBits-1:0]  r_t_id  [MaxOutstanding];
    logic [CmtCntBits-1:0] r_t_cmt [MaxOutstanding];
    logic                  w_found, w_acc, w_can_grant, w_empty, w_full, w_pop, w_zero;
    logic [SrcBits-1:0]    w_win, w_c;
    logic [NrReq-1:0]      w_ready;
    logic [CmtCntBits-1:0] w_beats, w_cmt;
    // scan from the priority pointer upwards, wrapping, and take the first valid requester
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_c     = r_rr_ptr;
        for (int k = 0; k < NrReq; k++) begin
            if (!w_found && bus.req_valid_i[w_c]) begin
                w_found = 1'b1;
                w_win   = w_c;
            end
            w_c = (w_c == SrcBits'(NrReq-1)) ? '0 : w_c + SrcBits'(1);
        end
    end
    assign w_empty = (r_wr == r_rd) && (r_wf == r_rf);
    assign w_full  = (r_wr == r_rd) && (r_wf != r_rf);
    assign w_pop   = !w_empty && bus.beat_done_i && (r_cnt == r_t_cmt[r_rd]);
    // a full tracker still takes a request when its head retires this cycle
    assign w_can_grant = ((r_state == EMPTY) || bus.meta_ready_i) && (!w_full || w_pop);
    assign w_acc   = w_found && w_can_grant;
    assign w_beats = bus.req_beats_i[w_win];
    assign w_zero  = (w_beats == '0);
    assign w_cmt   = w_zero ? '0 : w_beats - CmtCntBits'(1);
    always_comb begin
        w_ready = '0;
        if (w_acc) w_ready[w_win] = 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (w_acc && !rst_i) begin
            r_t_src[r_wr] <= w_win;
            r_t_id[r_wr]  <= bus.req_reqid_i[w_win];
            r_t_cmt[r_wr] <= w_cmt;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= EMPTY;
            r_rr_ptr     <= '0;
            r_meta_src   <= '0;
            r_meta_id    <= '0;
            r_meta_cmt   <= '0;
            r_done_valid <= 1'b0;
            r_done_src   <= '0;
            r_done_id    <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_wf         <= 1'b0;
            r_rf         <= 1'b0;
        end else begin
            r_done_valid <= w_pop;
            if (w_pop) begin
                r_done_src <= r_t_src[r_rd];
                r_done_id  <= r_t_id[r_rd];
            end
            if (w_acc) begin
                r_state    <= FULL;
                r_meta_src <= w_win;
                r_meta_id  <= bus.req_reqid_i[w_win];
                r_meta_cmt <= w_cmt;
                r_rr_ptr   <= (w_win == SrcBits'(NrReq-1)) ? '0 : w_win + SrcBits'(1);
                if (r_wr == PtrBits'(MaxOutstanding-1)) begin
                    r_wr <= '0;
                    r_wf <= ~r_wf;
                end else r_wr <= r_wr + PtrBits'(1);
            end else if (bus.meta_ready_i) r_state <= EMPTY;
            if (w_pop) begin
                r_cnt <= '0;
                if (r_rd == PtrBits'(MaxOutstanding-1)) begin
                    r_rd <= '0;
                    r_rf <= ~r_rf;
                end else r_rd <= r_rd + PtrBits'(1);
            end else if (bus.beat_done_i && !w_empty) r_cnt <= r_cnt + CmtCntBits'(1);
            if ((bus.beat_done_i && w_empty) || (w_acc && w_zero)) r_err <= 1'b1;
        end
    end
    assign bus.req_ready_o   = w_ready;
    assign bus.meta_valid_o  = (r_state == FULL);
    assign bus.meta_reqid_o  = r_meta_id;
    assign bus.meta_cmtcnt_o = r_meta_cmt;
    assign bus.meta_src_o    = r_meta_src;
    assign bus.done_valid_o  = r_done_valid;
    assign bus.done_src_o    = r_done_src;
    assign bus.done_reqid_o  = r_done_id;
    assign bus.busy_o        = (r_state == FULL) || !w_empty;
    assign bus.err_o         = r_err;
endmodule

// File: tb/tb_vlsu_meta_arbiter.sv
// tb_vlsu_meta_arbiter: directed scenario tasks with hand-computed expectations for vlsu_meta_arbiter.
module tb_vlsu_meta_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int total = 0;
    vlsu_meta_arbiter_if #(.NrReq(2), .CmtCntBits(8), .ReqIdBits(4)) bus ();
    vlsu_meta_arbiter #(.NrReq(2), .MaxOutstanding(4), .CmtCntBits(8), .ReqIdBits(4)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_inputs();
        bus.req_valid_i  = '0;
        bus.req_reqid_i  = '0;
        bus.req_beats_i  = {8'd1, 8'd1};
        bus.meta_ready_i = 1'b0;
        bus.beat_done_i  = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        bus.req_valid_i = 2'b11;
        #1;
        total++; if (bus.req_ready_o !== 2'b01) $display("FAIL reset_ready got %b want 01", bus.req_ready_o); else passed++;
        tick();
        total++; if (bus.meta_valid_o !== 1'b0) $display("FAIL reset_meta_valid got %b want 0", bus.meta_valid_o); else passed++;
        total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_o); else passed++;
        total++; if (bus.err_o !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err_o); else passed++;
        total++; if (bus.done_valid_o !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done_valid_o); else passed++;
        bus.req_valid_i = '0;
        rst = 1'b0;
    endtask
    task automatic test_round_robin();
        do_reset();
        bus.req_reqid_i  = {4'd2, 4'd1};
        bus.req_beats_i  = {8'd1, 8'd1};
        bus.meta_ready_i = 1'b1;
        bus.req_valid_i  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (bus.req_ready_o !== ((k % 2) ? 2'b10 : 2'b01)) $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready_o, (k % 2) ? 2'b10 : 2'b01); else passed++;
            tick();
            total++; if (bus.meta_valid_o !== 1'b1) $display("FAIL rr_meta_valid[%0d] got %b want 1", k, bus.meta_valid_o); else passed++;
            total++; if (bus.meta_src_o !== 1'(k % 2)) $display("FAIL rr_meta_src[%0d] got %0d want %0d", k, bus.meta_src_o, k % 2); else passed++;
        end
        total++; if (bus.req_ready_o !== 2'b00) $display("FAIL rr_full_ready got %b want 00", bus.req_ready_o); else passed++;
        bus.req_valid_i = '0;
        tick();
        total++; if (bus.meta_valid_o !== 1'b0) $display("FAIL rr_meta_drain got %b want 0", bus.meta_valid_o); else passed++;
        total++; if (bus.busy_o !== 1'b1) $display("FAIL rr_busy_inflight got %b want 1", bus.busy_o); else passed++;
        bus.beat_done_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (bus.done_valid_o !== 1'b1) $display("FAIL rr_done_valid[%0d] got %b want 1", k, bus.done_valid_o); else passed++;
            total++; if (bus.done_src_o !== 1'(k % 2)) $display("FAIL rr_done_src[%0d] got %0d want %0d", k, bus.done_src_o, k % 2); else passed++;
            total++; if (bus.done_reqid_o !== ((k % 2) ? 4'd2 : 4'd1)) $display("FAIL rr_done_reqid[%0d] got %0d want %0d", k, bus.done_reqid_o, (k % 2) ? 2 : 1); else passed++;
        end
        bus.beat_done_i = 1'b0;
        tick();
        total++; if (bus.done_valid_o !== 1'b0) $display("FAIL rr_done_end got %b want 0", bus.done_valid_o); else passed++;
        total++; if (bus.busy_o !== 1'b0) $display("FAIL rr_busy_end got %b want 0", bus.busy_o); else passed++;
        total++; if (bus.err_o !== 1'b0) $display("FAIL rr_err got %b want 0", bus.err_o); else passed++;
    endtask
    task automatic test_outstanding_limit();
        int acc;
        do_reset();
        acc = 0;
        bus.req_reqid_i  = {4'd0, 4'd3};
        bus.req_beats_i  = {8'd1, 8'd2};
        bus.meta_ready_i = 1'b1;
        bus.req_valid_i  = 2'b01;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (bus.req_ready_o[0]) acc++;
            tick();
        end
        total++; if (acc !== 4) $display("FAIL lim_accepted got %0d want 4", acc); else passed++;
        total++; if (bus.req_ready_o !== 2'b00) $display("FAIL lim_ready_full got %b want 00", bus.req_ready_o); else passed++;
        bus.beat_done_i = 1'b1;
        #1;
        total++; if (bus.req_ready_o !== 2'b00) $display("FAIL lim_ready_first_beat got %b want 00", bus.req_ready_o); else passed++;
        tick();
        #1;
        total++; if (bus.req_ready_o !== 2'b01) $display("FAIL lim_ready_same_cycle_pop got %b want 01", bus.req_ready_o); else passed++;
        tick();
        bus.beat_done_i = 1'b0;
        #1;
        total++; if (bus.done_valid_o !== 1'b1) $display("FAIL lim_done got %b want 1", bus.done_valid_o); else passed++;
        total++; if (bus.done_reqid_o !== 4'd3) $display("FAIL lim_done_reqid got %0d want 3", bus.done_reqid_o); else passed++;
        total++; if (bus.req_ready_o !== 2'b00) $display("FAIL lim_still_full got %b want 00", bus.req_ready_o); else passed++;
        total++; if (bus.meta_valid_o !== 1'b1) $display("FAIL lim_meta_valid got %b want 1", bus.meta_valid_o); else passed++;
        bus.req_valid_i = '0;
    endtask
    task automatic test_single_and_stall();
        do_reset();
        bus.req_reqid_i  = {4'd5, 4'd0};
        bus.req_beats_i  = {8'd3, 8'd1};
        bus.req_valid_i  = 2'b10;
        #1;
        total++; if (bus.req_ready_o !== 2'b10) $display("FAIL one_ready got %b want 10", bus.req_ready_o); else passed++;
        tick();
        total++; if (bus.meta_valid_o !== 1'b1) $display("FAIL one_meta_valid got %b want 1", bus.meta_valid_o); else passed++;
        total++; if (bus.meta_cmtcnt_o !== 8'd2) $display("FAIL one_cmtcnt got %0d want 2", bus.meta_cmtcnt_o); else passed++;
        total++; if (bus.meta_src_o !== 1'b1) $display("FAIL one_src got %0d want 1", bus.meta_src_o); else passed++;
        total++; if (bus.meta_reqid_o !== 4'd5) $display("FAIL one_reqid got %0d want 5", bus.meta_reqid_o); else passed++;
        bus.req_valid_i = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (bus.req_ready_o !== 2'b00) $display("FAIL stall_ready[%0d] got %b want 00", k, bus.req_ready_o); else passed++;
            tick();
            total++; if ({bus.meta_valid_o, bus.meta_reqid_o, bus.meta_cmtcnt_o} !== {1'b1, 4'd5, 8'd2}) $display("FAIL stall_payload[%0d] got %h want %h", k, {bus.meta_valid_o, bus.meta_reqid_o, bus.meta_cmtcnt_o}, {1'b1, 4'd5, 8'd2}); else passed++;
        end
        bus.req_valid_i  = '0;
        bus.meta_ready_i = 1'b1;
        tick();
        total++; if (bus.meta_valid_o !== 1'b0) $display("FAIL one_meta_taken got %b want 0", bus.meta_valid_o); else passed++;
        for (int k = 0; k < 3; k++) begin
            bus.beat_done_i = 1'b1;
            tick();
            bus.beat_done_i = 1'b0;
            total++; if (bus.done_valid_o !== (k == 2)) $display("FAIL one_done[%0d] got %b want %b", k, bus.done_valid_o, k == 2); else passed++;
        end
        total++; if ({bus.done_src_o, bus.done_reqid_o} !== {1'b1, 4'd5}) $display("FAIL one_done_id got %h want %h", {bus.done_src_o, bus.done_reqid_o}, {1'b1, 4'd5}); else passed++;
        tick();
        total++; if (bus.done_valid_o !== 1'b0) $display("FAIL one_done_single got %b want 0", bus.done_valid_o); else passed++;
        total++; if (bus.busy_o !== 1'b0) $display("FAIL one_busy got %b want 0", bus.busy_o); else passed++;
        total++; if (bus.err_o !== 1'b0) $display("FAIL one_err got %b want 0", bus.err_o); else passed++;
    endtask
    task automatic test_errors();
        bus.beat_done_i = 1'b1;
        tick();
        bus.beat_done_i = 1'b0;
        total++; if (bus.err_o !== 1'b1) $display("FAIL err_empty_beat got %b want 1", bus.err_o); else passed++;
        total++; if (bus.done_valid_o !== 1'b0) $display("FAIL err_no_done got %b want 0", bus.done_valid_o); else passed++;
        tick();
        tick();
        total++; if (bus.err_o !== 1'b1) $display("FAIL err_sticky got %b want 1", bus.err_o); else passed++;
        do_reset();
        total++; if (bus.err_o !== 1'b0) $display("FAIL err_cleared got %b want 0", bus.err_o); else passed++;
        bus.req_reqid_i  = {4'd0, 4'd7};
        bus.req_beats_i  = {8'd1, 8'd0};
        bus.meta_ready_i = 1'b1;
        bus.req_valid_i  = 2'b01;
        tick();
        bus.req_valid_i = '0;
        total++; if (bus.meta_cmtcnt_o !== 8'd0) $display("FAIL zero_cmtcnt got %0d want 0", bus.meta_cmtcnt_o); else passed++;
        total++; if (bus.err_o !== 1'b1) $display("FAIL zero_err got %b want 1", bus.err_o); else passed++;
        bus.beat_done_i = 1'b1;
        tick();
        bus.beat_done_i = 1'b0;
        total++; if ({bus.done_valid_o, bus.done_reqid_o} !== {1'b1, 4'd7}) $display("FAIL zero_done got %h want %h", {bus.done_valid_o, bus.done_reqid_o}, {1'b1, 4'd7}); else passed++;
    endtask
    task automatic test_reset_mid();
        do_reset();
        bus.req_reqid_i  = {4'd0, 4'd9};
        bus.req_beats_i  = {8'd1, 8'd4};
        bus.meta_ready_i = 1'b1;
        bus.req_valid_i  = 2'b01;
        tick();
        tick();
        tick();
        bus.req_valid_i = '0;
        total++; if (bus.busy_o !== 1'b1) $display("FAIL mid_busy_before got %b want 1", bus.busy_o); else passed++;
        rst = 1'b1;
        bus.beat_done_i = 1'b1;
        tick();
        total++; if (bus.busy_o !== 1'b0) $display("FAIL mid_busy_after got %b want 0", bus.busy_o); else passed++;
        total++; if (bus.done_valid_o !== 1'b0) $display("FAIL mid_done_after got %b want 0", bus.done_valid_o); else passed++;
        total++; if (bus.meta_valid_o !== 1'b0) $display("FAIL mid_meta_after got %b want 0", bus.meta_valid_o); else passed++;
        rst = 1'b0;
        bus.beat_done_i = 1'b0;
        tick();
        total++; if ({bus.done_valid_o, bus.busy_o, bus.err_o} !== 3'b000) $display("FAIL mid_quiet got %b want 000", {bus.done_valid_o, bus.busy_o, bus.err_o}); else passed++;
    endtask
    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_outstanding_limit();
        test_single_and_stall();
        test_errors();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
